dsp_mac_sequencer: RTL
======================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the term-count field.
REQ-002 SHALL have parameter OPM_DLY, default 2, cycles from operand issue to the product reaching the post-adder (A/B and M register stages).
REQ-003 SHALL have port CLK  input  1  the single clock; all logic rises on CLK.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  command strobe, sampled in IDLE only.
REQ-006 SHALL have port len  input  LEN_W  number of product terms to accumulate, sampled with start.
REQ-007 SHALL have port sub  input  1  1 = subtract each term from P (OPMODE[7]), sampled with start.
REQ-008 SHALL have port op_valid  input  1  operand pair presented on the A/B bus.
REQ-009 SHALL have port op_ready  output  1  sequencer accepts an operand pair this cycle.
REQ-010 SHALL have port OPMODE  output  8  DSP48A1 opmode, aligned to the post-adder stage.
REQ-011 SHALL have port CEP  output  1  P-register clock enable, aligned to the post-adder stage.
REQ-012 SHALL have port busy  output  1  high from command accept through res_valid.
REQ-013 SHALL have port res_valid  output  1  one-cycle pulse: P holds the final result.
REQ-014 SHALL have port err  output  1  one-cycle pulse: start with len = 0 rejected.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start=1 and len!=0 -> ISSUE next cycle, latch len into remaining-count and sub into a sub flag; start=1 and len=0 -> stay IDLE, err=1 next cycle.
REQ-017 ISSUE: op_ready=1; each cycle with op_valid=1 is a handshake, which decrements remaining-count and pushes one tag {first, last} into the delay line.
REQ-018 A cycle in ISSUE with op_valid=0 SHALL push a bubble tag; the bubble yields CEP=0 OPM_DLY cycles later, so P holds.
REQ-019 Tag decode: first term -> OPMODE=8'h01 (X=M, Z=0); later terms -> 8'h09 (X=M, Z=P); bit 7 = latched sub; CEP=1.
REQ-020 The handshake with remaining-count=1 SHALL move ISSUE -> DRAIN; op_ready=0 from the next cycle.
REQ-021 DRAIN SHALL last OPM_DLY+1 cycles (delay line plus P register), then move to DONE.
REQ-022 DONE SHALL last one cycle with res_valid=1, then move to IDLE; start during ISSUE, DRAIN or DONE SHALL be ignored with no err.
REQ-023 With no valid tag at the delay-line output, OPMODE SHALL be 8'h00 and CEP=0.
REQ-024 len = 2^LEN_W-1 SHALL complete without counter wrap; remaining-count SHALL never decrement below 1 in ISSUE.

Reset
REQ-025 RST=1 SHALL force, at the next CLK edge, state IDLE, all delay-line tags invalid, remaining-count 0, OPMODE=8'h00, CEP=0, op_ready=0, busy=0, res_valid=0, err=0, overriding any operation in progress.
REQ-026 A start asserted in the same cycle as RST SHALL be ignored.

Configuration
REQ-027 Macro DSP_MAC_SEQ_ROUND_EN: when defined, the last term's decoded OPMODE SHALL also set bit 5 (carry-in = 1, round-half-up with the CARRYINSEL=OPMODE5 setting); when undefined, OPMODE[5] SHALL always be 0.

Structure
REQ-028 Package dsp_seq_pkg SHALL hold the state enum and the OPMODE constants (OPM_ZERO 8'h00, OPM_LOAD 8'h01, OPM_ACC 8'h09, sub and carry bit positions).
REQ-029 Sub-module dsp_seq_delay SHALL implement the OPM_DLY-deep tag shift register {valid, first, last}, with synchronous clear on RST.

Verification
REQ-030 With OPM_DLY=2: start, len=3, op_valid held 1 -> OPMODE 01,09,09 with CEP=1 on cycles 3..5 after the first handshake, res_valid exactly once, busy low the cycle after.
REQ-031 len=4 with op_valid=0 on the second issue cycle -> one CEP=0 bubble in the OPMODE stream, 4 CEP pulses total, res_valid delayed by one cycle.
REQ-032 start with len=0 -> err pulse, busy stays 0, no CEP.
REQ-033 sub=1, len=2 -> OPMODE 81,89; start pulsed during DRAIN -> no effect.
REQ-034 RST asserted mid-ISSUE after 2 of 5 terms -> next cycle OPMODE=00, CEP=0, busy=0, no res_valid; a new start, len=1, then completes normally.
REQ-035 DSP_MAC_SEQ_ROUND_EN defined, len=3 -> last OPMODE 8'h29; undefined -> 8'h09.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// rtl/dsp_seq_pkg.sv - shared state, tag and OPMODE definitions for the DSP48A1 MAC sequencer
package dsp_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One tag per issue cycle; valid=0 marks a bubble that must not clock P.
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tag_t;

   localparam logic [7:0] OPM_ZERO      = 8'h00;
   localparam logic [7:0] OPM_LOAD      = 8'h01;
   localparam logic [7:0] OPM_ACC       = 8'h09;
   localparam int         OPM_SUB_BIT   = 7;
   localparam int         OPM_CARRY_BIT = 5;

   // First term loads P from M, later terms add onto P; carry-in rounds only the last term.
   function automatic logic [7:0] decode_tag(input tag_t tag, input logic sub, input logic round_en);
      logic [7:0] v;
      v                = tag.first ? OPM_LOAD : OPM_ACC;
      v[OPM_SUB_BIT]   = sub;
      v[OPM_CARRY_BIT] = round_en & tag.last;
      if (!tag.valid) begin
         v = OPM_ZERO;
      end
      return v;
   endfunction

endpackage

// File: rtl/dsp_seq_delay.sv
// rtl/dsp_seq_delay.sv - tag shift register matching the DSP A/B and M register latency
module dsp_seq_delay
   import dsp_seq_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic CLK,
   input  logic RST,
   input  tag_t i_tag,
   output tag_t o_tag
);

   tag_t r_pipe [DEPTH];

   // Shift one tag per cycle; reset empties every stage so no stale term reaches P.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - DSP48A1 multiply-accumulate sequencer (option: DSP_MAC_SEQ_ROUND_EN)
module dsp_mac_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int OPM_DLY = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             sub,
   input  logic             op_valid,
   output logic             op_ready,
   output logic [7:0]       OPMODE,
   output logic             CEP,
   output logic             busy,
   output logic             res_valid,
   output logic             err
);

`ifdef DSP_MAC_SEQ_ROUND_EN
   localparam logic ROUND_EN = 1'b1;
`else
   localparam logic ROUND_EN = 1'b0;
`endif

   // Drain covers the delay line plus the P register itself.
   localparam int               DRN_W    = $clog2(OPM_DLY + 1) + 1;
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(OPM_DLY);
   localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

   state_t           r_state;
   logic [LEN_W-1:0] r_remaining;
   logic             r_sub;
   logic             r_first;
   logic [DRN_W-1:0] r_drain_cnt;

   logic             w_hs;
   logic             w_last_hs;
   tag_t             w_push_tag;
   tag_t             w_out_tag;
   logic [7:0]       w_opm;

   assign w_hs      = (r_state == ST_ISSUE) && op_valid;
   assign w_last_hs = w_hs && (r_remaining == CNT_ONE);

   // Build the tag for this issue cycle; a non-handshake cycle becomes a bubble.
   always_comb begin
      w_push_tag       = '0;
      w_push_tag.valid = w_hs;
      w_push_tag.first = w_hs & r_first;
      w_push_tag.last  = w_last_hs;
   end

   dsp_seq_delay #(
      .DEPTH (OPM_DLY)
   ) u_delay (
      .CLK   (CLK),
      .RST   (RST),
      .i_tag (w_push_tag),
      .o_tag (w_out_tag)
   );

   assign w_opm = decode_tag(w_out_tag, r_sub, ROUND_EN);

   // Register the decoded opmode so it lands on the post-adder cycle of its product.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OPMODE <= OPM_ZERO;
         CEP    <= 1'b0;
      end else begin
         OPMODE <= w_opm;
         CEP    <= w_out_tag.valid;
      end
   end

   // Command FSM: accept, issue terms, wait for the pipeline to empty, flag the result.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_sub       <= 1'b0;
         r_first     <= 1'b0;
         r_drain_cnt <= '0;
         op_ready    <= 1'b0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         err         <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         err       <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     r_state     <= ST_ISSUE;
                     r_remaining <= len;
                     r_sub       <= sub;
                     r_first     <= 1'b1;
                     op_ready    <= 1'b1;
                     busy        <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (op_valid) begin
                  r_first <= 1'b0;
                  if (w_last_hs) begin
                     r_state     <= ST_DRAIN;
                     op_ready    <= 1'b0;
                     r_drain_cnt <= '0;
                  end else begin
                     r_remaining <= r_remaining - 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_drain_cnt == DRN_LAST) begin
                  r_state   <= ST_DONE;
                  res_valid <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state     <= ST_IDLE;
               busy        <= 1'b0;
               r_remaining <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
